// File: rtl/sb_pkg.sv
// Shared sizing constants and types for the register scoreboard.
package sb_pkg;

    localparam int NUM_REGS = 16;
    localparam int REG_W    = 4;
    localparam int MAX_PEND = 3;

    // Width of a counter that must hold the values 0..max_pend inclusive.
    function automatic int cnt_width(input int max_pend);
        return $clog2(max_pend + 1);
    endfunction

    localparam int CNT_W = cnt_width(MAX_PEND);

    typedef logic [REG_W-1:0] reg_idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/pend_counter.sv
// Saturating up/down counter of in-flight writes for one register or for
// the status flags. An increment and a decrement in the same cycle cancel.
module pend_counter #(
    parameter int MAX_PEND = 3,
    parameter int CNT_W    = sb_pkg::cnt_width(MAX_PEND)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             full,
    output logic             underflow
);
    import sb_pkg::*;

    assign nonzero = (count != '0);
    assign full    = (count == CNT_W'(MAX_PEND));

    // A lone decrement of an empty counter is an accounting error upstream.
    always_comb begin
        underflow = dec & ~inc & (count == '0);
    end

    // Count up on issue, down on retire; hold at the limits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc & ~dec & ~full) begin
            count <= count + CNT_W'(1);
        end else if (dec & ~inc & nonzero) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// Pipeline interlock: tracks in-flight register and status-flag writers,
// stalls ID on RAW dependences or counter saturation, and strobes issue.
module reg_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int REG_W    = 4,
    parameter int MAX_PEND = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    id_src1,
    input  logic                id_src1_used,
    input  logic [REG_W-1:0]    id_src2,
    input  logic                id_src2_used,
    input  logic                id_cond_used,
    input  logic                id_wb_en,
    input  logic [REG_W-1:0]    id_dest,
    input  logic                id_s,
    input  logic                freeze,
    input  logic                flush,
    input  logic                exe_s_done,
    input  logic                wb_wb_en,
    input  logic [REG_W-1:0]    wb_dest,
    output logic                hazard,
    output logic                issue,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                status_pending,
    output logic                err
);
    import sb_pkg::*;

    localparam int CW = cnt_width(MAX_PEND);

    logic [NUM_REGS-1:0] ret;
    logic [NUM_REGS-1:0] reg_inc;
    logic [NUM_REGS-1:0] reg_nz;
    logic [NUM_REGS-1:0] reg_full;
    logic [NUM_REGS-1:0] reg_uf;
    logic [NUM_REGS-1:0] eff_nz;
    logic [CW-1:0]       reg_cnt [NUM_REGS];

    logic [CW-1:0]       s_cnt;
    logic                s_nz;
    logic                s_full;
    logic                s_uf;
    logic                s_eff_nz;

    // One counter per architectural register, plus one for the status flags.
    for (genvar r = 0; r <= NUM_REGS; r++) begin : g_cnt
        if (r < NUM_REGS) begin : g_reg
            assign ret[r]     = wb_wb_en & (wb_dest == REG_W'(r));
            assign reg_inc[r] = issue & id_wb_en & (id_dest == REG_W'(r));
            // The register file writes before it is read, so a retiring
            // write no longer blocks its consumer.
            assign eff_nz[r]  = ((reg_cnt[r] - CW'(ret[r])) != '0);

            pend_counter #(
                .MAX_PEND (MAX_PEND),
                .CNT_W    (CW)
            ) u_cnt (
                .clk       (clk),
                .rst       (rst),
                .inc       (reg_inc[r]),
                .dec       (ret[r]),
                .count     (reg_cnt[r]),
                .nonzero   (reg_nz[r]),
                .full      (reg_full[r]),
                .underflow (reg_uf[r])
            );
        end else begin : g_status
            pend_counter #(
                .MAX_PEND (MAX_PEND),
                .CNT_W    (CW)
            ) u_cnt (
                .clk       (clk),
                .rst       (rst),
                .inc       (issue & id_s),
                .dec       (exe_s_done),
                .count     (s_cnt),
                .nonzero   (s_nz),
                .full      (s_full),
                .underflow (s_uf)
            );
        end
    end

    assign s_eff_nz       = ((s_cnt - CW'(exe_s_done)) != '0);
    assign busy_mask      = reg_nz;
    assign status_pending = s_nz;

    // Stall ID on any outstanding source/flag producer or a saturated counter.
    always_comb begin
        hazard = 1'b0;
        if (id_valid) begin
            hazard = (id_src1_used & eff_nz[id_src1])
                   | (id_src2_used & eff_nz[id_src2])
                   | (id_cond_used & s_eff_nz)
                   | (id_wb_en     & reg_full[id_dest])
                   | (id_s         & s_full);
        end
    end

    // Accept the ID instruction into EXE only when nothing holds it back.
    always_comb begin
        issue = id_valid & ~hazard & ~freeze & ~flush & rst;
    end

    // Sticky record of any retirement that had no matching issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if ((|reg_uf) | s_uf) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard using a behavioural count model
// and expectation queues.
module tb_reg_scoreboard;

    localparam int NR = 16;
    localparam int RW = 4;
    localparam int MP = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid;
    logic [RW-1:0] id_src1;
    logic          id_src1_used;
    logic [RW-1:0] id_src2;
    logic          id_src2_used;
    logic          id_cond_used;
    logic          id_wb_en;
    logic [RW-1:0] id_dest;
    logic          id_s;
    logic          freeze;
    logic          flush;
    logic          exe_s_done;
    logic          wb_wb_en;
    logic [RW-1:0] wb_dest;
    logic          hazard;
    logic          issue;
    logic [NR-1:0] busy_mask;
    logic          status_pending;
    logic          err;

    always #5 clk = ~clk;

    reg_scoreboard #(
        .NUM_REGS (NR),
        .REG_W    (RW),
        .MAX_PEND (MP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_src1        (id_src1),
        .id_src1_used   (id_src1_used),
        .id_src2        (id_src2),
        .id_src2_used   (id_src2_used),
        .id_cond_used   (id_cond_used),
        .id_wb_en       (id_wb_en),
        .id_dest        (id_dest),
        .id_s           (id_s),
        .freeze         (freeze),
        .flush          (flush),
        .exe_s_done     (exe_s_done),
        .wb_wb_en       (wb_wb_en),
        .wb_dest        (wb_dest),
        .hazard         (hazard),
        .issue          (issue),
        .busy_mask      (busy_mask),
        .status_pending (status_pending),
        .err            (err)
    );

    int   checks   = 0;
    int   failures = 0;

    int   mcnt [NR];
    int   mscnt;
    logic merr;

    typedef struct packed {
        logic hz;
        logic iss;
    } comb_exp_t;

    typedef struct packed {
        logic [NR-1:0] busy;
        logic          spend;
        logic          er;
    } state_exp_t;

    comb_exp_t  comb_q  [$];
    state_exp_t state_q [$];

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic clearInputs();
        id_valid     = 1'b0;
        id_src1      = '0;
        id_src1_used = 1'b0;
        id_src2      = '0;
        id_src2_used = 1'b0;
        id_cond_used = 1'b0;
        id_wb_en     = 1'b0;
        id_dest      = '0;
        id_s         = 1'b0;
        freeze       = 1'b0;
        flush        = 1'b0;
        exe_s_done   = 1'b0;
        wb_wb_en     = 1'b0;
        wb_dest      = '0;
    endtask

    task automatic modelReset();
        for (int i = 0; i < NR; i++) mcnt[i] = 0;
        mscnt = 0;
        merr  = 1'b0;
    endtask

    // Stall decision from the model's counts and the inputs currently driven.
    function automatic logic modelHazard();
        int e1, e2, es;
        if (!id_valid) return 1'b0;
        e1 = mcnt[id_src1];
        if (wb_wb_en && wb_dest == id_src1) e1 = e1 - 1;
        e2 = mcnt[id_src2];
        if (wb_wb_en && wb_dest == id_src2) e2 = e2 - 1;
        es = mscnt;
        if (exe_s_done) es = es - 1;
        if (id_src1_used && e1 != 0) return 1'b1;
        if (id_src2_used && e2 != 0) return 1'b1;
        if (id_cond_used && es != 0) return 1'b1;
        if (id_wb_en && mcnt[id_dest] == MP) return 1'b1;
        if (id_s && mscnt == MP) return 1'b1;
        return 1'b0;
    endfunction

    task automatic modelUpdate(input logic iss);
        logic up, down;
        for (int r = 0; r < NR; r++) begin
            up   = iss && id_wb_en && (id_dest == RW'(r));
            down = wb_wb_en && (wb_dest == RW'(r));
            if (up && !down && mcnt[r] < MP) mcnt[r] = mcnt[r] + 1;
            else if (down && !up) begin
                if (mcnt[r] == 0) merr = 1'b1;
                else mcnt[r] = mcnt[r] - 1;
            end
        end
        up   = iss && id_s;
        down = exe_s_done;
        if (up && !down && mscnt < MP) mscnt = mscnt + 1;
        else if (down && !up) begin
            if (mscnt == 0) merr = 1'b1;
            else mscnt = mscnt - 1;
        end
    endtask

    // Run one clock with the inputs already driven: predict, check the
    // combinational outputs, clock, then check the registered outputs.
    task automatic applyStimulus(input string tag);
        logic       h, iss;
        comb_exp_t  ce;
        state_exp_t se;
        #1;
        h   = modelHazard();
        iss = id_valid & ~h & ~freeze & ~flush & rst;
        comb_q.push_back('{hz: h, iss: iss});
        modelUpdate(iss);
        for (int r = 0; r < NR; r++) se.busy[r] = (mcnt[r] != 0);
        se.spend = (mscnt != 0);
        se.er    = merr;
        state_q.push_back(se);

        ce = comb_q.pop_front();
        checkOutput($sformatf("%s.hazard", tag), 32'(hazard), 32'(ce.hz));
        checkOutput($sformatf("%s.issue", tag), 32'(issue), 32'(ce.iss));
        @(posedge clk);
        #1;
        se = state_q.pop_front();
        checkOutput($sformatf("%s.busy_mask", tag), 32'(busy_mask), 32'(se.busy));
        checkOutput($sformatf("%s.status_pending", tag), 32'(status_pending), 32'(se.spend));
        checkOutput($sformatf("%s.err", tag), 32'(err), 32'(se.er));
        @(negedge clk);
    endtask

    task automatic writer(input logic [RW-1:0] d);
        clearInputs();
        id_valid = 1'b1;
        id_wb_en = 1'b1;
        id_dest  = d;
    endtask

    initial begin
        clearInputs();
        modelReset();
        rst = 1'b0;
        id_valid = 1'b1;
        #1;
        $display("[TB] reset state");
        checkOutput("reset.issue", 32'(issue), 32'd0);
        checkOutput("reset.busy_mask", 32'(busy_mask), 32'd0);
        checkOutput("reset.status_pending", 32'(status_pending), 32'd0);
        checkOutput("reset.err", 32'(err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        clearInputs();

        // ADD R1 then dependent SUB; SUB issues in R1's WB cycle.
        $display("[TB] RAW on R1");
        writer(4'd1);
        applyStimulus("add_r1");
        writer(4'd4);
        id_src1 = 4'd1;
        id_src1_used = 1'b1;
        applyStimulus("sub_stall0");
        checkOutput("sub_stall0.busy1", 32'(busy_mask[1]), 32'd1);
        applyStimulus("sub_stall1");
        wb_wb_en = 1'b1;
        wb_dest  = 4'd1;
        #1;
        checkOutput("sub_wb.issue_lit", 32'(issue), 32'd1);
        applyStimulus("sub_wb");
        checkOutput("sub_wb.busy1", 32'(busy_mask[1]), 32'd0);
        clearInputs();
        wb_wb_en = 1'b1;
        wb_dest  = 4'd4;
        applyStimulus("retire_r4");

        // Three writers saturate R2; the fourth waits for a retire.
        $display("[TB] saturation on R2");
        for (int i = 0; i < 3; i++) begin
            writer(4'd2);
            applyStimulus($sformatf("r2_w%0d", i));
        end
        writer(4'd2);
        #1;
        checkOutput("r2_w3.hazard_lit", 32'(hazard), 32'd1);
        applyStimulus("r2_w3_stall");
        wb_wb_en = 1'b1;
        wb_dest  = 4'd2;
        applyStimulus("r2_w3_retire");
        wb_wb_en = 1'b0;
        applyStimulus("r2_w3_go");
        for (int i = 0; i < 3; i++) begin
            clearInputs();
            wb_wb_en = 1'b1;
            wb_dest  = 4'd2;
            applyStimulus($sformatf("r2_ret%0d", i));
        end

        // CMP sets flags, BEQ waits for the status write.
        $display("[TB] status flags");
        clearInputs();
        id_valid = 1'b1;
        id_s     = 1'b1;
        applyStimulus("cmp");
        clearInputs();
        id_valid     = 1'b1;
        id_cond_used = 1'b1;
        applyStimulus("beq_stall");
        exe_s_done = 1'b1;
        applyStimulus("beq_go");
        checkOutput("beq_go.status_pending_lit", 32'(status_pending), 32'd0);

        // Freeze blocks issue but not retirement; flush blocks issue only.
        $display("[TB] freeze and flush");
        writer(4'd3);
        applyStimulus("w_r3");
        writer(4'd6);
        freeze   = 1'b1;
        wb_wb_en = 1'b1;
        wb_dest  = 4'd3;
        applyStimulus("freeze_ret_r3");
        writer(4'd7);
        flush = 1'b1;
        applyStimulus("flush");
        checkOutput("flush.busy_lit", 32'(busy_mask), 32'd0);

        // Retiring an empty register sets a sticky error.
        $display("[TB] underflow");
        clearInputs();
        wb_wb_en = 1'b1;
        wb_dest  = 4'd5;
        applyStimulus("underflow");
        clearInputs();
        applyStimulus("err_sticky");
        checkOutput("err_sticky.lit", 32'(err), 32'd1);

        // Mixed traffic, including shared src/dest indices.
        $display("[TB] random traffic");
        for (int i = 0; i < 60; i++) begin
            clearInputs();
            id_valid     = 1'($urandom_range(0, 1));
            id_src1      = RW'($urandom_range(0, 3));
            id_src1_used = 1'($urandom_range(0, 1));
            id_src2      = RW'($urandom_range(0, 3));
            id_src2_used = 1'($urandom_range(0, 1));
            id_cond_used = 1'($urandom_range(0, 1));
            id_wb_en     = 1'($urandom_range(0, 1));
            id_dest      = RW'($urandom_range(0, 3));
            id_s         = 1'($urandom_range(0, 1));
            freeze       = ($urandom_range(0, 5) == 0);
            flush        = ($urandom_range(0, 5) == 0);
            exe_s_done   = (mscnt != 0) && ($urandom_range(0, 2) == 0);
            wb_wb_en     = 1'($urandom_range(0, 1));
            wb_dest      = RW'($urandom_range(0, 3));
            applyStimulus($sformatf("rnd%0d", i));
        end

        // Asynchronous reset mid-cycle clears everything at once.
        $display("[TB] async reset");
        writer(4'd9);
        applyStimulus("pre_reset_w_r9");
        clearInputs();
        id_valid = 1'b1;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        modelReset();
        checkOutput("async_rst.busy_mask", 32'(busy_mask), 32'd0);
        checkOutput("async_rst.err", 32'(err), 32'd0);
        checkOutput("async_rst.status_pending", 32'(status_pending), 32'd0);
        checkOutput("async_rst.issue", 32'(issue), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        clearInputs();
        writer(4'd9);
        applyStimulus("post_reset_w_r9");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
